// File: rtl/brick_field_engine.sv
// Brick field, ball-to-brick collision (vertical then corner), combo scoring and round FSM.
// Optional build macro MULTI_HIT_EN: the top two brick rows need two hits to clear.
module brick_field_engine #(
   parameter int unsigned BRICK_ROWS = 7,
   parameter int unsigned BRICK_COLS = 8,
   parameter int unsigned BRICK_W    = 2,
   parameter int unsigned TOP_ROW    = 1,
   parameter int unsigned LOSS_ROW   = 11,
   parameter int unsigned ROW_W      = 4,
   parameter int unsigned COL_W      = 4,
   parameter int unsigned SCORE_W    = 10,
   parameter int unsigned COMBO_MAX  = 4
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             ball_valid,
   input  logic [ROW_W-1:0]                 ball_row,
   input  logic [COL_W-1:0]                 ball_col,
   input  logic [1:0]                       ball_dir,
   input  logic                             paddle_hit,
   output logic [BRICK_ROWS*BRICK_COLS-1:0] bricks,
   output logic [SCORE_W-1:0]               score,
   output logic [3:0]                       level,
   output logic [2:0]                       combo,
   output logic                             hit,
   output logic                             bounce_v,
   output logic                             bounce_h,
   output logic [1:0]                       state,
   output logic                             game_over,
   output logic                             level_clear
);

   localparam int unsigned N_BRICKS = BRICK_ROWS * BRICK_COLS;
   localparam int unsigned COL_SH   = $clog2(BRICK_W);
   localparam int unsigned RX_W     = ROW_W + 1;
   localparam int unsigned CX_W     = COL_W + 1;
   localparam int unsigned SUM_W    = SCORE_W + 1;

   localparam logic [RX_W-1:0]    RX_ONE    = RX_W'(1);
   localparam logic [CX_W-1:0]    CX_ONE    = CX_W'(1);
   localparam logic [SUM_W-1:0]   SUM_ONE   = SUM_W'(1);
   localparam logic [SUM_W-1:0]   SUM_MAX   = {1'b0, {SCORE_W{1'b1}}};
   localparam logic [ROW_W-1:0]   LOSS_R    = ROW_W'(LOSS_ROW);
   localparam logic [2:0]         COMBO_CAP = 3'(COMBO_MAX);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StPlay  = 2'b01,
      StClear = 2'b10,
      StOver  = 2'b11
   } state_e;

   state_e               r_state, w_state_d;
   logic [N_BRICKS-1:0]  r_bricks, w_bricks_d;
   logic [SCORE_W-1:0]   r_score, w_score_d;
   logic [3:0]           r_level, w_level_d;
   logic [2:0]           r_combo, w_combo_d;
   logic                 r_hit, w_hit_d;
   logic                 r_bounce_v, w_bounce_v_d;
   logic                 r_bounce_h, w_bounce_h_d;

   logic [RX_W-1:0]      w_trow;
   logic [CX_W-1:0]      w_vcol, w_ccol;
   logic [N_BRICKS-1:0]  w_vmask, w_cmask, w_tmask;
   logic                 w_vhit, w_chit;
   logic [SUM_W-1:0]     w_sum;

`ifdef MULTI_HIT_EN
   localparam int unsigned N_STRONG = ((BRICK_ROWS < 2) ? BRICK_ROWS : 2) * BRICK_COLS;
   logic [N_STRONG-1:0]  r_strong, w_strong_d;
   logic                 w_strong_hit;
`endif

   // Wrapped (underflowed) coordinates land far outside the field and match no brick.
   always_comb begin
      w_trow = ball_dir[1] ? ({1'b0, ball_row} + RX_ONE) : ({1'b0, ball_row} - RX_ONE);
      w_vcol = {1'b0, ball_col};
      w_ccol = ball_dir[0] ? (w_vcol + CX_ONE) : (w_vcol - CX_ONE);
   end

   always_comb begin
      w_vmask = '0;
      w_cmask = '0;
      for (int r = 0; r < int'(BRICK_ROWS); r++) begin
         for (int c = 0; c < int'(BRICK_COLS); c++) begin
            if (w_trow == RX_W'(TOP_ROW + r)) begin
               w_vmask[r*BRICK_COLS+c] = ((w_vcol >> COL_SH) == CX_W'(c));
               w_cmask[r*BRICK_COLS+c] = ((w_ccol >> COL_SH) == CX_W'(c));
            end
         end
      end
   end

   // A corner cell inside the vertical brick has the same (absent) bit, so it never scores.
   assign w_vhit  = |(w_vmask & r_bricks);
   assign w_chit  = |(w_cmask & r_bricks);
   assign w_tmask = w_vhit ? w_vmask : w_cmask;
   assign w_sum   = {1'b0, r_score} + SUM_W'(r_combo) + SUM_ONE;

`ifdef MULTI_HIT_EN
   assign w_strong_hit = |(w_tmask[N_STRONG-1:0] & r_strong);
`endif

   always_comb begin
      w_state_d    = r_state;
      w_bricks_d   = r_bricks;
      w_score_d    = r_score;
      w_level_d    = r_level;
      w_combo_d    = r_combo;
      w_hit_d      = 1'b0;
      w_bounce_v_d = 1'b0;
      w_bounce_h_d = 1'b0;
`ifdef MULTI_HIT_EN
      w_strong_d   = r_strong;
`endif
      case (r_state)
         StIdle, StOver: begin
            if (start) begin
               w_state_d  = StPlay;
               w_bricks_d = '1;
               w_score_d  = '0;
               w_combo_d  = '0;
`ifdef MULTI_HIT_EN
               w_strong_d = '1;
`endif
            end
         end
         StClear: begin
            if (start) begin
               w_state_d  = StPlay;
               w_bricks_d = '1;
               w_combo_d  = '0;
               if (r_level != 4'hF) w_level_d = r_level + 4'd1;
`ifdef MULTI_HIT_EN
               w_strong_d = '1;
`endif
            end
         end
         StPlay: begin
            if (ball_valid) begin
               if (ball_row == LOSS_R) begin
                  w_state_d = StOver;
               end else if (w_vhit || w_chit) begin
                  w_hit_d      = 1'b1;
                  w_bounce_v_d = 1'b1;
                  w_bounce_h_d = !w_vhit;
`ifdef MULTI_HIT_EN
                  if (w_strong_hit) begin
                     w_strong_d = r_strong & ~w_tmask[N_STRONG-1:0];
                  end else
`endif
                  begin
                     w_bricks_d = r_bricks & ~w_tmask;
                     w_score_d  = (w_sum > SUM_MAX) ? SUM_MAX[SCORE_W-1:0] : w_sum[SCORE_W-1:0];
                     w_combo_d  = (r_combo < COMBO_CAP) ? (r_combo + 3'd1) : COMBO_CAP;
                     if (w_bricks_d == '0) w_state_d = StClear;
                  end
               end
            end
         end
         default: ;
      endcase
      // The scoring path above already consumed the old combo.
      if (paddle_hit) w_combo_d = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= StIdle;
         r_bricks   <= '1;
         r_score    <= '0;
         r_level    <= '0;
         r_combo    <= '0;
         r_hit      <= 1'b0;
         r_bounce_v <= 1'b0;
         r_bounce_h <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_bricks   <= w_bricks_d;
         r_score    <= w_score_d;
         r_level    <= w_level_d;
         r_combo    <= w_combo_d;
         r_hit      <= w_hit_d;
         r_bounce_v <= w_bounce_v_d;
         r_bounce_h <= w_bounce_h_d;
      end
   end

`ifdef MULTI_HIT_EN
   always_ff @(posedge clock) begin
      if (reset) r_strong <= '1;
      else       r_strong <= w_strong_d;
   end
`endif

   assign bricks      = r_bricks;
   assign score       = r_score;
   assign level       = r_level;
   assign combo       = r_combo;
   assign hit         = r_hit;
   assign bounce_v    = r_bounce_v;
   assign bounce_h    = r_bounce_h;
   assign state       = r_state;
   assign game_over   = (r_state == StOver);
   assign level_clear = (r_state == StClear);

endmodule
